regfile_onehot_sb: RTL
======================

Name: regfile_onehot_sb

Overview:
- Processor register file that sits directly downstream of the 5-to-32 write-select decoder; consumes its 32 one-hot write strobes.
- Holds 32 x DATA_WIDTH registers; r0 is hardwired to zero.
- Provides two combinational read ports.
- Adds a per-register pending (scoreboard) bitmap: issue sets a register's bit, writeback clears it, and a stall is raised on RAW/WAW hazards.

Parameters:
DATA_WIDTH, 32, width of each register and of the data ports.

Ports:
clock  input  1  single clock; all state updates on rising edge.
ctrl_reset  input  1  asynchronous, active-high reset.
ctrl_writeEnable  input  1  global write enable for the writeback port.
write_onehot  input  32  one-hot write-select from the 5-to-32 decoder; all-zero is legal.
data_writeReg  input  DATA_WIDTH  writeback data.
ctrl_readRegA  input  5  read address, port A.
ctrl_readRegB  input  5  read address, port B.
data_readRegA  output  DATA_WIDTH  read data, port A.
data_readRegB  output  DATA_WIDTH  read data, port B.
issue_valid  input  1  an instruction is attempting to issue this cycle.
issue_reg  input  5  destination register of the issuing instruction.
busy  output  32  pending-write bitmap; bit 0 is always 0.
stall  output  1  issue blocked by a hazard (combinational).
onehot_err  output  1  sticky error flag: a multi-hot write strobe was seen.

Behaviour:
- Reset: ctrl_reset=1 asynchronously clears all registers, busy and onehot_err to 0.
  - While reset is held, data_readRegA/B read 0 and stall=0.
  - Reset dominates any write or issue in the same cycle.
- Write:
  - On a rising edge with ctrl_writeEnable=1, every register i (1..31) with write_onehot[i]=1 loads data_writeReg.
  - write_onehot[0] is ignored; r0 is never written.
  - ctrl_writeEnable=0 means no write, regardless of write_onehot.
- One-hot check:
  - If ctrl_writeEnable=1 and write_onehot has more than one bit set, onehot_err is set at that edge.
  - onehot_err stays set until reset.
  - All flagged registers are still written; behaviour stays deterministic.
- Read:
  - Combinational, zero latency: data_readRegX = reg[ctrl_readRegX]; address 0 returns 0.
  - A same-cycle write is not visible until after the edge, unless the optional feature is enabled.
- Scoreboard:
  - hazA = busy[ctrl_readRegA] and ctrl_readRegA!=0.
  - hazB = busy[ctrl_readRegB] and ctrl_readRegB!=0.
  - hazW = busy[issue_reg] and issue_reg!=0.
  - stall = issue_valid and (hazA or hazB or hazW).
  - On an edge where ctrl_writeEnable=1, each i with write_onehot[i]=1 clears busy[i].
  - On an edge where issue_valid=1, stall=0 and issue_reg!=0, busy[issue_reg] is set.
  - If set and clear hit the same bit on the same edge, set wins: the newly issued producer owns the register.
  - Issuing to r0 never sets a busy bit and never stalls on its destination.
- Boundaries:
  - Writeback to a register that is not busy still updates the data; busy is unchanged (stays 0).
  - Reset deasserting mid-sequence leaves an empty scoreboard and a zeroed file.
  - All 31 busy bits may be set at once; no overflow condition exists.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - A read port whose address matches a register being written this cycle (ctrl_writeEnable=1, write_onehot[addr]=1, addr!=0) returns data_writeReg combinationally.
  - Busy bits being cleared this cycle are treated as 0 in the stall equation, so the consumer issues in the writeback cycle.
- Undefined:
  - Reads return only the stored value.
  - stall uses the registered busy value; the consumer issues one cycle after writeback.

Test Plan:
- Reset, then write 0xDEADBEEF with write_onehot=32'h0000_0020 -> next cycle ctrl_readRegA=5 returns 0xDEADBEEF; ctrl_readRegB=0 returns 0.
- write_onehot=32'h0000_0001, data 0x1234 -> r0 still reads 0; busy[0]=0.
- Issue to r7 (busy[7]=1), next cycle issue_valid=1 with ctrl_readRegA=7 -> stall=1.
  - Writeback to r7 -> busy[7]=0 after the edge.
  - With the macro, stall=0 in the writeback cycle and data_readRegA=writeback data; without it, stall drops one cycle later.
- Same edge: writeback clears r9 while a non-stalled issue targets r9 -> busy[9]=1 after the edge.
- write_onehot=32'h0000_0006, enable=1 -> onehot_err=1; r1 and r2 both updated; onehot_err stays 1 until ctrl_reset.
- Assert ctrl_reset mid-clock-period with busy=32'h0000_0F00 -> busy, onehot_err and all reads go to 0 immediately, before the next edge.

Source files
------------

// File: rtl/regfile_onehot_sb.sv
// 32 x DATA_WIDTH register file fed by one-hot write strobes, with a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward writeback data/busy-clears into the same cycle's reads and stall.
module regfile_onehot_sb #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [31:0]           write_onehot,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [4:0]            ctrl_readRegA,
    input  logic [4:0]            ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_reg,
    output logic [31:0]           busy,
    output logic                  stall,
    output logic                  onehot_err
);

    logic [DATA_WIDTH-1:0] regs_q [32];
    logic [31:0]           busy_q, busy_d;
    logic                  onehot_err_q, onehot_err_d;
    logic [31:0]           wr_vec, busy_view, set_vec;
    logic                  multi_hot, haz_a, haz_b, haz_w;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;

    // Strobe for r0 is dropped here so r0 is never written and never cleared.
    assign wr_vec    = ctrl_writeEnable ? {write_onehot[31:1], 1'b0} : 32'd0;
    assign multi_hot = ctrl_writeEnable && ((write_onehot & (write_onehot - 32'd1)) != 32'd0);

`ifdef REGFILE_BYPASS_EN
    assign busy_view = busy_q & ~wr_vec;
`else
    assign busy_view = busy_q;
`endif

    assign haz_a = busy_view[ctrl_readRegA] && (ctrl_readRegA != 5'd0);
    assign haz_b = busy_view[ctrl_readRegB] && (ctrl_readRegB != 5'd0);
    assign haz_w = busy_view[issue_reg] && (issue_reg != 5'd0);
    assign stall = issue_valid && (haz_a || haz_b || haz_w);

    // Set is OR-ed after the clear so a new producer owns a register written back on the same edge.
    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        set_vec = 32'd0;
        if (issue_valid && !stall && (issue_reg != 5'd0)) begin
            set_vec[issue_reg] = 1'b1;
        end
        busy_d       = (busy_q & ~wr_vec) | set_vec;
        busy_d[0]    = 1'b0;
        onehot_err_d = onehot_err_q | multi_hot;
    end

    always_comb begin
        rd_a = (ctrl_readRegA == 5'd0) ? '0 : regs_q[ctrl_readRegA];
        rd_b = (ctrl_readRegB == 5'd0) ? '0 : regs_q[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
        if (!ctrl_reset && wr_vec[ctrl_readRegA]) rd_a = data_writeReg;
        if (!ctrl_reset && wr_vec[ctrl_readRegB]) rd_b = data_writeReg;
`endif
    end

    // NOTE: the storage array is reset on purpose: reset must leave a zeroed file, so it maps to flops, not RAM.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            busy_q       <= 32'd0;
            onehot_err_q <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wr_vec[i]) regs_q[i] <= data_writeReg;
            end
            busy_q       <= busy_d;
            onehot_err_q <= onehot_err_d;
        end
    end

    assign data_readRegA = rd_a;
    assign data_readRegB = rd_b;
    assign busy          = busy_q;
    assign onehot_err    = onehot_err_q;

endmodule
